// File: rtl/rs_pkg.sv
// -----------------------------------------------------------------------------
// rs_pkg
// Shared definitions for the result serializer:
//   state_t      - serializer FSM states
//   frame_len    - total serial frame length in bits (start + payload + parity + stop)
//   even_parity  - XOR-reduction of a payload (payloads up to MAX_PAYLOAD_W bits)
// -----------------------------------------------------------------------------
package rs_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int MAX_PAYLOAD_W = 64;

    function automatic int frame_len(input int coord_w, input int mad_w, input int parity_en);
        return coord_w + mad_w + 2 + parity_en;
    endfunction

    // Narrower payloads are zero-extended by the caller; zeros do not change the XOR.
    function automatic logic even_parity(input logic [MAX_PAYLOAD_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/rs_fifo.sv
// -----------------------------------------------------------------------------
// rs_fifo
// Synchronous FIFO, first-word-fall-through read (dout always shows the head).
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   push, din     - write request and data; ignored while full
//   pop           - read request; ignored while empty
//   dout          - head-of-queue word
//   full, empty   - status, decoded from the registered occupancy count
// -----------------------------------------------------------------------------
module rs_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;   // must represent DEPTH itself

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];

    // NOTE: storage carries no reset; its contents are only observable through
    // entries the pointers mark valid, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values regardless of statement order.
    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/result_serializer.sv
// -----------------------------------------------------------------------------
// result_serializer
// Buffers {coordinate, mad} results from the block-matching array and shifts
// each one out MSB-first on a single wire as: start(0), payload, [even parity],
// stop(1). Every bit is held BAUD_DIV cycles.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid/in_ready - result handshake; in_ready = FIFO not full
//   coordinate, mad   - result fields (coordinate lands in the payload MSBs)
//   serialport        - registered serial line, idle high
//   busy              - registered: frame in progress or FIFO non-empty
// -----------------------------------------------------------------------------
module result_serializer
    import rs_pkg::*;
#(
    parameter int COORD_W   = 8,
    parameter int MAD_W     = 12,
    parameter int DEPTH     = 4,
    parameter int BAUD_DIV  = 1,
    parameter int PARITY_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] coordinate,
    input  logic [MAD_W-1:0]   mad,
    output logic               serialport,
    output logic               busy
);

    // Payload width is the frame length minus the framing bits.
    localparam int FRAME_LEN = frame_len(COORD_W, MAD_W, PARITY_EN);
    localparam int FRAME_W   = FRAME_LEN - 2 - PARITY_EN;
    localparam int BIT_W     = $clog2(FRAME_W + 1);
    localparam int BAUD_W    = $clog2(BAUD_DIV + 1);

    state_t               r_state;
    logic [BAUD_W-1:0]    r_baud;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [FRAME_W-1:0]   r_shift;
    logic                 r_parity;
    logic                 r_serial;
    logic                 r_busy;

    logic [FRAME_W-1:0]   w_dout;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_baud_end;
    logic                 w_pop;

    assign w_baud_end = (r_baud == BAUD_W'(BAUD_DIV - 1));
    // Pop when idle, or on the last stop-bit cycle so frames run back to back.
    assign w_pop = !w_empty && ((r_state == S_IDLE) || (r_state == S_STOP && w_baud_end));

    rs_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .din   ({coordinate, mad}),
        .pop   (w_pop),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    // The line register follows the state one cycle later, so the start bit
    // appears one edge after the pop and each bit still lasts BAUD_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_serial  <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_busy <= (r_state != S_IDLE) || !w_empty;

            case (r_state)
                S_START:  r_serial <= 1'b0;
                S_DATA:   r_serial <= r_shift[FRAME_W-1];
                S_PARITY: r_serial <= r_parity;
                default:  r_serial <= 1'b1;
            endcase

            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift  <= w_dout;
                        r_parity <= even_parity(MAX_PAYLOAD_W'(w_dout));
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud    <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_shift <= r_shift << 1;
                        if (r_bit_cnt == BIT_W'(FRAME_W - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift  <= w_dout;
                            r_parity <= even_parity(MAX_PAYLOAD_W'(w_dout));
                            r_state  <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = !w_full;
    assign serialport = r_serial;
    assign busy       = r_busy;

endmodule

// File: doc/result_serializer.md
# result_serializer

Parametrised successor to the fixed 20-bit result output register. It accepts {coordinate, MAD} results from the block-matching array through a valid/ready handshake and buffers them in a small FIFO. It shifts each result off-chip on a single-wire serial port as a framed word: start bit, payload, optional even parity, stop bit. It sits at the output of the full-search motion-estimation core, after the minimum-MAD comparator.

## Interface
- COORD_W, 8: coordinate field width (bits)
- MAD_W, 12: MAD field width (bits)
- DEPTH, 4: FIFO depth in results; power of two, ≥2
- BAUD_DIV, 1: clock cycles per serial bit; ≥1
- PARITY_EN, 1: 1 = append even-parity bit, 0 = no parity bit
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  result present on coordinate/mad
- in_ready  output  1  block can accept a result this cycle
- coordinate  input  COORD_W  best-match coordinate
- mad  input  MAD_W  MAD value of that coordinate
- serialport  output  1  serial line; idle high
- busy  output  1  frame in progress, or FIFO non-empty

## Operation
- Accept on rising edge with in_valid & in_ready; word {coordinate, mad} (coordinate in MSBs) written to FIFO.
- in_ready = !fifo_full; derived from registered count only, no combinational path from in_valid.
- No bypass path: an empty FIFO still takes one cycle before the frame starts.
- Frame, bits MSB-first: start (0), FRAME_W = COORD_W+MAD_W payload bits, parity (only if PARITY_EN, XOR of payload), stop (1).
- Frame length: FRAME_W+2+PARITY_EN bits, each held exactly BAUD_DIV cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: FIFO non-empty → pop, load shift register, go to START.
  - START → DATA after BAUD_DIV cycles.
  - DATA: shifts FRAME_W bits, tracked by bit counter of width clog2(FRAME_W+1).
  - DATA → PARITY, or → STOP if PARITY_EN=0.
  - PARITY → STOP.
  - STOP, last cycle: FIFO non-empty → pop and go directly to START (no idle gap); else → IDLE.
- Push and pop on the same edge are legal when not full; count unchanged.
- Full: in_ready low; in_valid ignored, no drop, no overwrite.
- Pointers wrap modulo DEPTH.
- serialport and busy are registered outputs.

## Timing
- Reset values: serialport=1, in_ready=1, busy=0, FSM=IDLE, FIFO empty, counters 0.
- rst mid-frame: frame aborted; serialport returns high asynchronously; buffered results discarded.
- Latency: result accepted at edge E0 → serialport low (start bit) from edge E2.
- Throughput: one frame per (FRAME_W+2+PARITY_EN)·BAUD_DIV cycles when FIFO stays non-empty.
- busy rises at the edge after the first accept; falls at the edge that ends the stop bit with FIFO empty.
- After a full-FIFO stall, in_ready rises the cycle after the pop edge.

## Structure
- Shared package rs_pkg holds:
  - FSM state enum
  - function frame_len(COORD_W, MAD_W, PARITY_EN)
  - function even_parity(vector)
- One sub-module: rs_fifo, a synchronous FIFO parametrised by WIDTH and DEPTH.
  - Ports: full, empty, push, pop, dout.
  - Count register is one bit wider than the pointers.
- Top level holds the FSM, baud counter, bit counter and shift register.

## Test plan
- Defaults, BAUD_DIV=1, coordinate=0xA5, mad=0x3C0 → from E2: 0, 1010_0101_0011_1100_0000, parity 0, stop 1 (23 bits); then serialport=1, busy=0.
- coordinate=0x01, mad=0x000, PARITY_EN=1 → parity bit 1; same stimulus with PARITY_EN=0 → 22-bit frame, no parity slot.
- BAUD_DIV=4, one result → each bit held exactly 4 cycles; frame lasts 92 cycles.
- DEPTH=4, in_valid held high with 6 distinct results → exactly 5 accepted before in_ready falls.
  - in_ready rises one cycle after each subsequent pop.
  - Frames are emitted in order with no idle cycles between stop and next start.
- Assert rst during the 10th DATA bit with 2 results queued → serialport=1 immediately; in_ready=1, busy=0.
  - No further frames after release until a new accept.
